// File: rtl/lif_neuron_multi.sv
// Multi-synapse leaky integrate-and-fire neuron with a saturating membrane,
// a refractory period after each spike, and a saturating spike counter.
module lif_neuron_multi #(
   parameter int W     = 8,
   parameter int N     = 4,
   parameter int SH_W  = 3,
   parameter int REF_W = 4,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [N-1:0]       syn,
   input  logic [N*W-1:0]     weights,
   input  logic [SH_W-1:0]    tau_shift,
   input  logic [W-1:0]       threshold,
   input  logic [W-1:0]       v_reset,
   input  logic [REF_W-1:0]   refrac,
   output logic               spike,
   output logic [W-1:0]       V,
   output logic               refractory,
   output logic [CNT_W-1:0]   spike_count
);

   localparam int SW = W + $clog2(N) + 1;

   typedef enum logic {INTEG, REFRAC} state_t;

   state_t           state;
   logic [REF_W-1:0] refrac_cnt;
   logic [W-1:0]     leaked;
   logic [SW-1:0]    sum;
   logic [W-1:0]     sat_sum;
   logic             fire;

   // A logical shift by >= W yields zero, so large tau_shift naturally means no leak.
   always_comb begin
      leaked = V - (V >> tau_shift);
      sum    = SW'(leaked);
      for (int unsigned i = 0; i < N; i++) begin
         if (syn[i]) sum = sum + SW'(weights[i*W +: W]);
      end
      sat_sum = (sum[SW-1:W] != '0) ? '1 : sum[W-1:0];
      fire    = (sat_sum >= threshold);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= INTEG;
         refrac_cnt  <= '0;
         V           <= '0;
         spike       <= 1'b0;
         refractory  <= 1'b0;
         spike_count <= '0;
      end else if (!en) begin
         spike <= 1'b0;
      end else begin
         case (state)
            INTEG: begin
               if (fire) begin
                  spike <= 1'b1;
                  V     <= v_reset;
                  if (spike_count != '1) spike_count <= spike_count + 1'b1;
                  if (refrac != '0) begin
                     state      <= REFRAC;
                     refrac_cnt <= refrac;
                     refractory <= 1'b1;
                  end
               end else begin
                  spike <= 1'b0;
                  V     <= sat_sum;
               end
            end
            REFRAC: begin
               spike      <= 1'b0;
               V          <= v_reset;
               refrac_cnt <= refrac_cnt - 1'b1;
               if (refrac_cnt == REF_W'(1)) begin
                  state      <= INTEG;
                  refractory <= 1'b0;
               end
            end
            default: state <= INTEG;
         endcase
      end
   end

endmodule
